// File: rtl/mmio_access_unit.sv
// Sequenced data-side access unit: decodes CPU loads/stores into data memory or IO channels, inserts memory wait states, stalls the CPU and flags bus errors.
// Optional define MMIO_IO_SIGNEXT_EN makes IO loads sign-extend the channel value instead of zero-extending it.
module mmio_access_unit #(
  parameter int          DATA_W   = 32,
  parameter int          IO_W     = 16,
  parameter int          IO_CH    = 4,
  parameter int          MEM_WAIT = 2,
  parameter logic [31:0] IO_BASE  = 32'hFFFFFC00
) (
  input  logic                   iCpuClock,
  input  logic                   iCpuReset,
  input  logic                   iReq,
  input  logic                   iWe,
  input  logic [31:0]            iAddr,
  input  logic [DATA_W-1:0]      iWdata,
  output logic                   oStall,
  output logic                   oDone,
  output logic [DATA_W-1:0]      oRdata,
  output logic                   oBusError,
  output logic                   oMemEn,
  output logic                   oMemWe,
  output logic [31:0]            oMemAddr,
  output logic [DATA_W-1:0]      oMemWdata,
  input  logic [DATA_W-1:0]      iMemRdata,
  output logic [IO_CH-1:0]       oIoWe,
  output logic [IO_CH-1:0]       oIoRe,
  output logic [IO_W-1:0]        oIoWdata,
  input  logic [IO_CH*IO_W-1:0]  iIoRdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MEM  = 2'd1;
  localparam logic [1:0] IO   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic              weQ;
  logic              errQ;
  logic [29:0]       wordQ;
  logic [DATA_W-1:0] wdataQ;
  logic [2:0]        waitCnt;

  logic              isIo;
  logic              ioErr;
  logic              memErr;
  logic              reqErr;
  logic [IO_W-1:0]   ioSlice;
  logic [DATA_W-1:0] ioExt;
  logic [IO_CH-1:0]  ioSel;

  // Channel number lives in address bits [7:4], i.e. wordQ[5:2] once latched.
  assign isIo   = (iAddr[31:10] == IO_BASE[31:10]);
  assign ioErr  = ({1'b0, iAddr[7:4]} >= 5'(IO_CH)) || (iAddr[9:8] != 2'b00) || (iAddr[3:0] != 4'b0000);
  assign memErr = (iAddr[1:0] != 2'b00);
  assign reqErr = isIo ? ioErr : memErr;

  always_comb begin
    ioSlice = '0;
    ioSel   = '0;
    for (int k = 0; k < IO_CH; k++) begin
      if (wordQ[5:2] == 4'(k)) begin
        ioSlice  = iIoRdata[k*IO_W +: IO_W];
        ioSel[k] = 1'b1;
      end
    end
  end

`ifdef MMIO_IO_SIGNEXT_EN
  assign ioExt = {{(DATA_W-IO_W){ioSlice[IO_W-1]}}, ioSlice};
`else
  assign ioExt = {{(DATA_W-IO_W){1'b0}}, ioSlice};
`endif

  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      state   <= IDLE;
      weQ     <= 1'b0;
      errQ    <= 1'b0;
      wordQ   <= '0;
      wdataQ  <= '0;
      waitCnt <= '0;
      oRdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iReq) begin
            weQ     <= iWe;
            errQ    <= reqErr;
            wordQ   <= iAddr[31:2];
            wdataQ  <= iWdata;
            waitCnt <= '0;
            if (reqErr) begin
              oRdata <= '0;
              state  <= DONE;
            end else begin
              state  <= isIo ? IO : MEM;
            end
          end
        end
        // The counter starts at 0 on entry, so MEM lasts MEM_WAIT+1 cycles.
        MEM: begin
          if (waitCnt == 3'(MEM_WAIT)) begin
            if (!weQ) oRdata <= iMemRdata;
            state <= DONE;
          end else begin
            waitCnt <= waitCnt + 3'd1;
          end
        end
        IO: begin
          if (!weQ) oRdata <= ioExt;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oStall    = ((state == IDLE) && iReq) || (state == MEM) || (state == IO);
  assign oDone     = (state == DONE);
  assign oBusError = (state == DONE) && errQ;
  assign oMemEn    = (state == MEM);
  assign oMemWe    = (state == MEM) && weQ;
  assign oMemAddr  = {wordQ, 2'b00};
  assign oMemWdata = wdataQ;
  assign oIoWe     = ((state == IO) && weQ)  ? ioSel : '0;
  assign oIoRe     = ((state == IO) && !weQ) ? ioSel : '0;
  assign oIoWdata  = wdataQ[IO_W-1:0];

endmodule

// File: tb/tb_mmio_access_unit.sv
// Self-checking bench for mmio_access_unit: scoreboard of expected completions plus per-scenario strobe checks.
module tb_mmio_access_unit;
  localparam int DATA_W = 32;
  localparam int IO_W   = 16;
  localparam int IO_CH  = 4;

`ifdef MMIO_IO_SIGNEXT_EN
  localparam logic [31:0] IO3_EXP = 32'hFFFF8001;
`else
  localparam logic [31:0] IO3_EXP = 32'h00008001;
`endif

  logic                  iCpuClock = 1'b0;
  logic                  iCpuReset = 1'b1;
  logic                  iReq = 1'b0;
  logic                  iWe = 1'b0;
  logic [31:0]           iAddr = '0;
  logic [DATA_W-1:0]     iWdata = '0;
  logic                  oStall, oDone, oBusError, oMemEn, oMemWe;
  logic [DATA_W-1:0]     oRdata, oMemWdata, iMemRdata;
  logic [31:0]           oMemAddr;
  logic [IO_CH-1:0]      oIoWe, oIoRe;
  logic [IO_W-1:0]       oIoWdata;
  logic [IO_CH*IO_W-1:0] iIoRdata = {16'h8001, 16'h9ABC, 16'h5678, 16'h1234};
  logic [DATA_W-1:0]     memData = '0;
  logic                  useModel = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        busErr;
    int          lat;
  } exp_t;
  exp_t sbQ[$];

  typedef struct {
    int          lat;
    int          memEnCnt;
    int          memWeCnt;
    int          ioWeCnt;
    int          ioReCnt;
    int          stallCnt;
    logic [3:0]  ioWeOr;
    logic [3:0]  ioReOr;
    logic [31:0] memAddrSeen;
    logic [31:0] memWdataSeen;
    logic [15:0] ioWdataSeen;
    logic [31:0] rdata;
    logic        busErr;
    logic        acceptStall;
  } obs_t;

  // Memory model: either a fixed word, or an address-derived pattern for streams.
  assign iMemRdata = useModel ? (oMemAddr ^ 32'hA5A50000) : memData;

  mmio_access_unit dut (
    .iCpuClock(iCpuClock), .iCpuReset(iCpuReset), .iReq(iReq), .iWe(iWe),
    .iAddr(iAddr), .iWdata(iWdata), .oStall(oStall), .oDone(oDone),
    .oRdata(oRdata), .oBusError(oBusError), .oMemEn(oMemEn), .oMemWe(oMemWe),
    .oMemAddr(oMemAddr), .oMemWdata(oMemWdata), .iMemRdata(iMemRdata),
    .oIoWe(oIoWe), .oIoRe(oIoRe), .oIoWdata(oIoWdata), .iIoRdata(iIoRdata)
  );

  always #5 iCpuClock = ~iCpuClock;

  // Issues one access and records what the DUT does until oDone (lat stays 0 on timeout).
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata, output obs_t o);
    logic done;
    o = '{default: '0};
    @(negedge iCpuClock);
    iReq = 1'b1; iWe = we; iAddr = addr; iWdata = wdata;
    #1 o.acceptStall = oStall;
    for (int i = 1; i <= 20; i++) begin
      @(negedge iCpuClock);
      done = oDone;
      if (oMemEn) begin
        if (o.memEnCnt == 0) o.memAddrSeen = oMemAddr;
        o.memEnCnt++;
      end
      if (oMemWe) begin
        o.memWdataSeen = oMemWdata;
        o.memWeCnt++;
      end
      if (oIoWe != 4'b0) begin
        o.ioWdataSeen = oIoWdata;
        o.ioWeCnt++;
      end
      if (oIoRe != 4'b0) o.ioReCnt++;
      o.ioWeOr = o.ioWeOr | oIoWe;
      o.ioReOr = o.ioReOr | oIoRe;
      if (!done && oStall) o.stallCnt++;
      iReq = 1'b0; iAddr = 32'h0BAD0000; iWdata = 32'hFFFFFFFF;
      if (done) begin
        o.lat = i; o.rdata = oRdata; o.busErr = oBusError;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge iCpuClock);
    checks++; if ({oStall, oDone, oBusError, oMemEn, oMemWe, oIoWe, oIoRe} !== '0) begin
      errors++; $display("[TB] FAIL reset strobes: got %b want 0", {oStall, oDone, oBusError, oMemEn, oMemWe, oIoWe, oIoRe});
    end
    checks++; if (oRdata !== 32'h0) begin errors++; $display("[TB] FAIL reset rdata: got %h want 0", oRdata); end
    checks++; if (oMemAddr !== 32'h0) begin errors++; $display("[TB] FAIL reset memAddr: got %h want 0", oMemAddr); end
    iCpuReset = 1'b0;
  endtask

  task automatic test_mem_load;
    obs_t o; exp_t e;
    memData = 32'hDEADBEEF;
    sbQ.push_back('{32'hDEADBEEF, 1'b0, 4});
    applyStimulus(1'b0, 32'h00000040, 32'h0, o);
    e = sbQ.pop_front();
    checks++; if (o.lat !== e.lat) begin errors++; $display("[TB] FAIL memLoad latency: got %0d want %0d", o.lat, e.lat); end
    checks++; if (o.rdata !== e.rdata) begin errors++; $display("[TB] FAIL memLoad rdata: got %h want %h", o.rdata, e.rdata); end
    checks++; if (o.busErr !== e.busErr) begin errors++; $display("[TB] FAIL memLoad busErr: got %b want %b", o.busErr, e.busErr); end
    checks++; if (o.memEnCnt !== 3 || o.memWeCnt !== 0) begin
      errors++; $display("[TB] FAIL memLoad strobes: got en=%0d we=%0d want en=3 we=0", o.memEnCnt, o.memWeCnt);
    end
    checks++; if (o.stallCnt !== 3 || o.acceptStall !== 1'b1) begin
      errors++; $display("[TB] FAIL memLoad stall: got busy=%0d accept=%b want 3 and 1", o.stallCnt, o.acceptStall);
    end
    checks++; if (o.memAddrSeen !== 32'h40) begin errors++; $display("[TB] FAIL memLoad addr: got %h want 00000040", o.memAddrSeen); end
    checks++; if ((o.ioWeOr | o.ioReOr) !== 4'b0) begin errors++; $display("[TB] FAIL memLoad io strobes: got %b want 0", o.ioWeOr | o.ioReOr); end
    @(negedge iCpuClock);
    checks++; if (oDone !== 1'b0) begin errors++; $display("[TB] FAIL memLoad done pulse width: got %b want 0", oDone); end
  endtask

  task automatic test_mem_store;
    obs_t o; exp_t e;
    sbQ.push_back('{32'hDEADBEEF, 1'b0, 4});
    applyStimulus(1'b1, 32'h00000080, 32'h12345678, o);
    e = sbQ.pop_front();
    checks++; if (o.lat !== e.lat) begin errors++; $display("[TB] FAIL memStore latency: got %0d want %0d", o.lat, e.lat); end
    checks++; if (o.rdata !== e.rdata) begin errors++; $display("[TB] FAIL memStore rdata kept: got %h want %h", o.rdata, e.rdata); end
    checks++; if (o.memWeCnt !== 3 || o.memWdataSeen !== 32'h12345678) begin
      errors++; $display("[TB] FAIL memStore write: got we=%0d data=%h want 3 12345678", o.memWeCnt, o.memWdataSeen);
    end
  endtask

  task automatic test_io_store;
    obs_t o; exp_t e;
    sbQ.push_back('{32'hDEADBEEF, 1'b0, 2});
    applyStimulus(1'b1, 32'hFFFFFC10, 32'h0001A5A5, o);
    e = sbQ.pop_front();
    checks++; if (o.lat !== e.lat) begin errors++; $display("[TB] FAIL ioStore latency: got %0d want %0d", o.lat, e.lat); end
    checks++; if (o.ioWeOr !== 4'b0010 || o.ioWeCnt !== 1) begin
      errors++; $display("[TB] FAIL ioStore strobe: got %b x%0d want 0010 x1", o.ioWeOr, o.ioWeCnt);
    end
    checks++; if (o.ioWdataSeen !== 16'hA5A5) begin errors++; $display("[TB] FAIL ioStore wdata: got %h want a5a5", o.ioWdataSeen); end
    checks++; if (o.memEnCnt !== 0 || o.ioReOr !== 4'b0) begin
      errors++; $display("[TB] FAIL ioStore other strobes: got memEn=%0d re=%b want 0", o.memEnCnt, o.ioReOr);
    end
    checks++; if (o.rdata !== e.rdata) begin errors++; $display("[TB] FAIL ioStore rdata kept: got %h want %h", o.rdata, e.rdata); end
  endtask

  task automatic test_io_load;
    obs_t o; exp_t e;
    sbQ.push_back('{IO3_EXP, 1'b0, 2});
    applyStimulus(1'b0, 32'hFFFFFC30, 32'h0, o);
    e = sbQ.pop_front();
    checks++; if (o.lat !== e.lat) begin errors++; $display("[TB] FAIL ioLoad3 latency: got %0d want %0d", o.lat, e.lat); end
    checks++; if (o.rdata !== e.rdata) begin errors++; $display("[TB] FAIL ioLoad3 rdata: got %h want %h", o.rdata, e.rdata); end
    checks++; if (o.ioReOr !== 4'b1000 || o.ioReCnt !== 1 || o.ioWeOr !== 4'b0) begin
      errors++; $display("[TB] FAIL ioLoad3 strobe: got re=%b x%0d we=%b want 1000 x1 0000", o.ioReOr, o.ioReCnt, o.ioWeOr);
    end
    sbQ.push_back('{32'h00005678, 1'b0, 2});
    applyStimulus(1'b0, 32'hFFFFFC10, 32'h0, o);
    e = sbQ.pop_front();
    checks++; if (o.rdata !== e.rdata || o.ioReOr !== 4'b0010) begin
      errors++; $display("[TB] FAIL ioLoad1: got %h re=%b want %h re=0010", o.rdata, o.ioReOr, e.rdata);
    end
  endtask

  task automatic test_errors;
    obs_t o; exp_t e;
    logic [31:0] addrs [4] = '{32'hFFFFFC50, 32'h00000042, 32'hFFFFFD00, 32'hFFFFFC14};
    for (int i = 0; i < 4; i++) begin
      sbQ.push_back('{32'h0, 1'b1, 1});
      applyStimulus(1'b0, addrs[i], 32'h0, o);
      e = sbQ.pop_front();
      checks++; if (o.lat !== e.lat || o.busErr !== e.busErr || o.rdata !== e.rdata) begin
        errors++; $display("[TB] FAIL error %h: got lat=%0d err=%b rdata=%h want %0d %b %h", addrs[i], o.lat, o.busErr, o.rdata, e.lat, e.busErr, e.rdata);
      end
      checks++; if (o.memEnCnt + o.ioWeCnt + o.ioReCnt !== 0) begin
        errors++; $display("[TB] FAIL error %h strobes: got %0d want 0", addrs[i], o.memEnCnt + o.ioWeCnt + o.ioReCnt);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int nDone = 0, firstIdx = 0, secondIdx = 0;
    logic stallAtDone = 1'b1;
    useModel = 1'b1;
    sbQ.push_back('{32'hA5A50000, 1'b0, 4});
    sbQ.push_back('{32'hA5A50004, 1'b0, 5});
    @(negedge iCpuClock);
    iReq = 1'b1; iWe = 1'b0; iAddr = 32'h0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge iCpuClock);
      if (i == 1) iAddr = 32'h100;
      if (oDone) begin
        e = sbQ.pop_front();
        checks++; if (oRdata !== e.rdata) begin errors++; $display("[TB] FAIL b2b rdata %0d: got %h want %h", nDone, oRdata, e.rdata); end
        if (nDone == 0) begin firstIdx = i; stallAtDone = oStall; iAddr = 32'h4; end
        else secondIdx = i;
        nDone++;
      end
      if (nDone == 1 && i == firstIdx + 2) iReq = 1'b0;
      if (nDone == 2) break;
    end
    iReq = 1'b0; useModel = 1'b0;
    sbQ.delete();
    checks++; if (nDone !== 2) begin errors++; $display("[TB] FAIL b2b completions: got %0d want 2", nDone); end
    checks++; if (firstIdx !== 4 || secondIdx - firstIdx !== 5) begin
      errors++; $display("[TB] FAIL b2b timing: got first=%0d gap=%0d want 4 5", firstIdx, secondIdx - firstIdx);
    end
    checks++; if (stallAtDone !== 1'b0) begin errors++; $display("[TB] FAIL b2b stall in done: got %b want 0", stallAtDone); end
  endtask

  task automatic test_reset_mid;
    obs_t o; exp_t e;
    int doneSeen = 0;
    memData = 32'h55AA55AA;
    @(negedge iCpuClock);
    iReq = 1'b1; iWe = 1'b0; iAddr = 32'h8;
    @(negedge iCpuClock);
    iReq = 1'b0;
    @(negedge iCpuClock);
    checks++; if (oMemEn !== 1'b1) begin errors++; $display("[TB] FAIL midReset pre memEn: got %b want 1", oMemEn); end
    iCpuReset = 1'b1;
    #1;
    checks++; if (oMemEn !== 1'b0 || oStall !== 1'b0) begin
      errors++; $display("[TB] FAIL midReset drop: got memEn=%b stall=%b want 0 0", oMemEn, oStall);
    end
    @(negedge iCpuClock);
    iCpuReset = 1'b0;
    repeat (6) begin
      @(negedge iCpuClock);
      if (oDone) doneSeen++;
    end
    checks++; if (doneSeen !== 0) begin errors++; $display("[TB] FAIL midReset spurious done: got %0d want 0", doneSeen); end
    memData = 32'h0BADF00D;
    sbQ.push_back('{32'h0BADF00D, 1'b0, 4});
    applyStimulus(1'b0, 32'h00000010, 32'h0, o);
    e = sbQ.pop_front();
    checks++; if (o.lat !== e.lat || o.rdata !== e.rdata) begin
      errors++; $display("[TB] FAIL midReset recovery: got lat=%0d rdata=%h want %0d %h", o.lat, o.rdata, e.lat, e.rdata);
    end
  endtask

  initial begin
    test_reset;
    test_mem_load;
    test_mem_store;
    test_io_store;
    test_io_load;
    test_errors;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
